// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset controller: FSM states,
// ALU operation classes, opcodes and ALU control codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

endpackage

// File: rtl/alu_decoder.sv
// Combinational map from the FSM's ALU operation class and the instruction
// function fields to the ALU control code.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from addi, which must never subtract
                    3'b000:  alucontrol = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alucontrol = ALU_SLT;
                    3'b110:  alucontrol = ALU_OR;
                    3'b111:  alucontrol = ALU_AND;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: sequences fetch, decode, execute, memory access and
// writeback, and drives the ALU operand/operation selects.
module multicycle_controller
    import ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       adrsrc,
    output logic       memwrite,
    output logic       irwrite,
    output logic [1:0] resultsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] immsrc,
    output logic       regwrite,
    output logic [2:0] alucontrol,
    output logic       illegal_instr
);

    // state    | meaning
    // FETCH    | read instruction at PC, PC+4 -> PC when mem_ready
    // DECODE   | old PC + imm precomputed; dispatch on op
    // MEMADR   | rs1 + imm;  MEMREAD/MEMWB load,  MEMWRITE store
    // EXECUTER | rs1 op rs2; EXECUTEI rs1 op imm; ALUWB writes rd
    // BEQ      | rs1 - rs2, take branch on zero; JAL jump, then ALUWB

    state_t state, state_next;
    aluop_t aluop;

    logic pcwrite_raw, memwrite_raw, irwrite_raw, regwrite_raw, illegal_raw;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_FETCH;
        else          state <= state_next;
    end

    always_comb begin
        state_next   = state;
        pcwrite_raw  = 1'b0;
        adrsrc       = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        illegal_raw  = 1'b0;
        resultsrc    = 2'b00;
        alusrca      = 2'b00;
        alusrcb      = 2'b00;
        aluop        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                alusrcb     = 2'b10;
                resultsrc   = 2'b10;
                irwrite_raw = mem_ready;
                pcwrite_raw = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXECUTER;
                    OP_ITYPE:     state_next = S_EXECUTEI;
                    OP_BEQ:       state_next = S_BEQ;
                    OP_JAL:       state_next = S_JAL;
                    default: begin
                        illegal_raw = 1'b1;
                        state_next  = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                state_next = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adrsrc = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                resultsrc    = 2'b01;
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end
            S_MEMWRITE: begin
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alusrca    = 2'b10;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                aluop      = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                regwrite_raw = 1'b1;
                state_next   = S_FETCH;
            end
            S_BEQ: begin
                alusrca     = 2'b10;
                aluop       = ALUOP_SUB;
                pcwrite_raw = zero;
                state_next  = S_FETCH;
            end
            S_JAL: begin
                alusrca     = 2'b01;
                alusrcb     = 2'b10;
                pcwrite_raw = 1'b1;
                state_next  = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    always_comb begin
        case (op)
            OP_SW:   immsrc = 2'b01;
            OP_BEQ:  immsrc = 2'b10;
            OP_JAL:  immsrc = 2'b11;
            default: immsrc = 2'b00;
        endcase
    end

    // FETCH follows mem_ready directly, so enables are masked while in reset
    assign pcwrite       = pcwrite_raw  & reset_n;
    assign irwrite       = irwrite_raw  & reset_n;
    assign memwrite      = memwrite_raw & reset_n;
    assign regwrite      = regwrite_raw & reset_n;
    assign illegal_instr = illegal_raw  & reset_n;

    alu_decoder u_alu_decoder (
        .aluop      (aluop),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7b5   (funct7b5),
        .alucontrol (alucontrol)
    );

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I subset core (lw, sw, R-type, I-type ALU, beq, jal).
- Sits directly upstream of the ALU. It drives the ALU's 3-bit operation select and operand muxes, and consumes the ALU zero flag for branch resolution.
- It also sequences instruction fetch, memory access and register writeback, with a memory-ready stall handshake.

Parameters:
- None. All encodings are fixed in the shared package.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- op  in  7  instruction[6:0], taken from the instruction register
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- zero  in  1  ALU zero flag (ALU sum == 0)
- mem_ready  in  1  memory has completed the current access this cycle
- pcwrite  out  1  PC register enable
- adrsrc  out  1  memory address select: 0 = PC, 1 = ALU-out register
- memwrite  out  1  data memory write strobe
- irwrite  out  1  instruction register and old-PC register enable
- resultsrc  out  2  result select: 00 = ALU-out register, 01 = read data, 10 = ALU result
- alusrca  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1 register
- alusrcb  out  2  ALU B select: 00 = rs2 register, 01 = immediate, 10 = constant 4
- immsrc  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J
- regwrite  out  1  register file write enable
- alucontrol  out  3  ALU operation: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_instr  out  1  one-cycle pulse when an unsupported opcode is decoded

Behaviour:
- Clock and reset: single clock domain (clk). reset_n is asynchronous and active-low.
  - On reset assertion, state goes to FETCH immediately.
  - While reset_n is low, pcwrite, irwrite, memwrite, regwrite and illegal_instr are forced to 0.
  - All other outputs take their FETCH values.
- State register: the only sequential element. All outputs are combinational (Moore, plus mem_ready/zero gating).
- States and per-state outputs. Any enable or select not listed is 0.
  - FETCH: adrsrc=0, alusrca=00, alusrcb=10, aluop=ADD, resultsrc=10.
    - irwrite = pcwrite = mem_ready.
    - Stays in FETCH while mem_ready=0, then goes to DECODE.
  - DECODE: alusrca=01, alusrcb=01, aluop=ADD, computing the branch/jump target.
    - Next state by op: lw/sw -> MEMADR, R-type -> EXECUTER, I-type -> EXECUTEI, beq -> BEQ, jal -> JAL.
    - Any other op: illegal_instr=1, next state FETCH; the PC has already advanced.
  - MEMADR: alusrca=10, alusrcb=01, aluop=ADD. Next is MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: adrsrc=1, resultsrc=00. Holds until mem_ready, then goes to MEMWB.
  - MEMWB: resultsrc=01, regwrite=1. Next FETCH.
  - MEMWRITE: adrsrc=1, resultsrc=00.
    - memwrite=1 held every cycle until mem_ready.
    - Next FETCH on the cycle mem_ready=1.
  - EXECUTER: alusrca=10, alusrcb=00, aluop=FUNCT. Next ALUWB.
  - EXECUTEI: alusrca=10, alusrcb=01, aluop=FUNCT. Next ALUWB.
  - ALUWB: resultsrc=00, regwrite=1. Next FETCH.
  - BEQ: alusrca=10, alusrcb=00, aluop=SUB, resultsrc=00. pcwrite=zero. Next FETCH.
  - JAL: alusrca=01, alusrcb=10, aluop=ADD, resultsrc=00, pcwrite=1. Next ALUWB, which writes PC+4 to rd.
- Opcodes: lw 0000011, sw 0100011, R-type 0110011, I-type 0010011, beq 1100011, jal 1101111.
- immsrc depends on op only, in every state:
  - lw and I-type: 00; sw: 01; beq: 10; jal: 11.
  - Unknown op: 00.
- ALU decode (aluop to alucontrol):
  - ADD gives 000; SUB gives 001.
  - FUNCT decodes funct3:
    - 000: gives 001 only when op[5] & funct7b5 (R-type sub); otherwise 000. addi never subtracts.
    - 010: 101 (slt).
    - 110: 011 (or).
    - 111: 010 (and).
    - Any other funct3: 000.
  - The controller never emits 100, 110 or 111.
- Latency in cycles, with zero wait states: lw 5, sw 4, R-type and I-type 4, beq 3, jal 4, illegal 2.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: the instruction is abandoned, no write enable fires, and execution resumes at FETCH.

Decomposition:
- Package ctrl_pkg holds:
  - state_t enum (11 states);
  - aluop_t enum: ADD, SUB, FUNCT;
  - opcode localparams;
  - alucontrol localparams matching the ALU encodings above.
- One sub-module, alu_decoder: a purely combinational map from aluop, funct3, op[5] and funct7b5 to alucontrol.
- The FSM and the pcwrite gating stay in multicycle_controller.

Test Plan:
- add, op=0110011, funct3=000, funct7b5=0, mem_ready=1:
  - states FETCH, DECODE, EXECUTER, ALUWB;
  - alucontrol=000 in EXECUTER;
  - regwrite=1 only in cycle 4.
- sub and addi:
  - op=0110011, funct7b5=1, funct3=000 gives alucontrol=001.
  - op=0010011, funct7b5=1, funct3=000 gives alucontrol=000.
  - funct3 110/111/010 give 011/010/101.
- lw with mem_ready low for 2 cycles in FETCH and 3 cycles in MEMREAD:
  - irwrite pulses once, when mem_ready rises;
  - regwrite and resultsrc=01 in MEMWB;
  - total latency 10 cycles.
- beq, alucontrol=001 in BEQ:
  - zero=1 gives pcwrite=1 in BEQ;
  - zero=0 gives pcwrite=0;
  - both cases return to FETCH after 3 cycles.
- op=1111111: illegal_instr=1 for exactly the DECODE cycle, then FETCH, with no regwrite or memwrite.
- sw with reset_n pulled low mid-MEMWRITE while mem_ready=0:
  - memwrite drops to 0 asynchronously, before the next clock edge;
  - after release, the first cycle is FETCH with irwrite=mem_ready.
